// File: rtl/seq_mult32_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_mult32_if
// Purpose  : Handshake and operand/result bundle between the controller that
//            issues multiplies and the sequential 32x32 multiplier.
// Signals  : start  - request a multiply (controller -> multiplier)
//            mcand  - 32-bit multiplicand
//            mplier - 32-bit multiplier
//            busy   - operation in progress (multiplier -> controller)
//            done   - one-cycle completion pulse
//            prod   - 64-bit registered product
// Modports : master (controller side), slave (multiplier side)
// Revision : 1.0 - initial release
// ============================================================================
interface seq_mult32_if;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [63:0] prod;

  modport master (
    output start, mcand, mplier,
    input  busy, done, prod
  );

  modport slave (
    input  start, mcand, mplier,
    output busy, done, prod
  );
endinterface
`default_nettype wire

// File: rtl/seq_mult32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_mult32
// Purpose  : Unsigned 32x32 -> 64-bit shift-add multiplier. One iteration per
//            cycle: the high half of the accumulator is added to the
//            multiplicand (when the current multiplier bit is set) and the
//            33-bit sum, carry included, is shifted back into the accumulator.
// Ports    : clk   - system clock, all state on rising edge
//            rst_n - asynchronous active-low reset
//            bus   - seq_mult32_if.slave (start/mcand/mplier in,
//                    busy/done/prod out)
// Params   : ITER  - number of shift-add iterations (equal to operand width)
// Macros   : ZERO_SKIP_EN - when defined, a start with a zero operand jumps
//            straight to the completion cycle with a zero product.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult32 #(
  parameter int ITER = 32
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  seq_mult32_if.slave bus
);

  localparam int                 c_cnt_w   = $clog2(ITER);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(ITER - 1);

  localparam logic [1:0]         c_st_idle = 2'd0;
  localparam logic [1:0]         c_st_run  = 2'd1;
  localparam logic [1:0]         c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_mcand;
  logic [63:0]        r_acc;
  logic [63:0]        r_prod;

  logic               w_accept;
  logic               w_skip;
  logic               w_last;
  logic [32:0]        w_sum;
  logic [63:0]        w_acc_nxt;
  logic               w_busy;
  logic               w_done;

  // A new operation may be taken in IDLE and in the DONE cycle (back-to-back).
  assign w_accept = bus.start && (r_state != c_st_run);
  assign w_last   = (r_cnt == c_last);

`ifdef ZERO_SKIP_EN
  assign w_skip = w_accept && ((bus.mcand == 32'd0) || (bus.mplier == 32'd0));
`else
  assign w_skip = 1'b0;
`endif

  // Carry-out is kept as bit 32 so the shifted result stays exact.
  assign w_sum     = r_acc[0] ? ({1'b0, r_acc[63:32]} + {1'b0, r_mcand})
                              :  {1'b0, r_acc[63:32]};
  assign w_acc_nxt = {w_sum, r_acc[31:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_done: begin
        if (w_skip) begin
          w_state_nxt = c_st_done;
        end else if (w_accept) begin
          w_state_nxt = c_st_run;
        end else begin
          w_state_nxt = c_st_idle;
        end
      end
      c_st_run: begin
        if (w_last) begin
          w_state_nxt = c_st_done;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode: busy/done are direct decodes of the registered state.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_st_run:  w_busy = 1'b1;
      c_st_done: w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration, result commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mcand <= 32'd0;
      r_acc   <= 64'd0;
      r_prod  <= 64'd0;
    end else if (w_skip) begin
      r_prod  <= 64'd0;
    end else if (w_accept) begin
      r_mcand <= bus.mcand;
      r_acc   <= {32'd0, bus.mplier};
      r_cnt   <= '0;
    end else if (r_state == c_st_run) begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_prod <= w_acc_nxt;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.prod = r_prod;

endmodule
`default_nettype wire
